// File: rtl/menu_bar_n_pkg.sv
// -----------------------------------------------------------------------------
// menu_bar_n_pkg
// Shared constants for the OLED menu bar: RGB565 colour defaults, default tile
// geometry, and a helper that tests whether a pixel column falls inside a tab
// tile.
// -----------------------------------------------------------------------------
package menu_bar_n_pkg;

   // RGB565 colour defaults
   localparam logic [15:0] COL_IDLE_DEF   = 16'hAEDF;
   localparam logic [15:0] COL_CURSOR_DEF = 16'hFAAE;
   localparam logic [15:0] COL_ACTIVE_DEF = 16'h07E0;
   localparam logic [15:0] COL_BG_DEF     = 16'h10F2;

   // Default tile geometry, in pixels
   localparam int X0_DEF        = 7;
   localparam int TAB_W_DEF     = 10;
   localparam int TAB_PITCH_DEF = 18;
   localparam int BAR_Y0_DEF    = 3;
   localparam int BAR_Y1_DEF    = 7;
   localparam int BAND_Y1_DEF   = 10;

   // True when column x lies inside tile k. Integer arithmetic keeps tiles
   // that extend past the right edge of the panel from wrapping; such
   // columns are simply never presented, so they never match.
   function automatic logic in_tile(input int x, input int k, input int x0,
                                    input int w, input int pitch);
      int lo;
      lo = x0 + (k * pitch);
      return (x >= lo) && (x <= (lo + w - 1));
   endfunction

endpackage

// File: rtl/menu_bar_n_blink_div.sv
// -----------------------------------------------------------------------------
// menu_blink_div
// Free-running divider that counts 0..DIV-1 and toggles a blink phase each
// time the count wraps. The phase therefore holds for DIV cycles at a time.
//
// Ports
//   clk    in   sole clock
//   reset  in   synchronous, active-high; clears count and phase
//   phase  out  registered blink phase (0 straight out of reset)
// -----------------------------------------------------------------------------
module menu_blink_div #(
   parameter int DIV = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic phase
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] count_r;
   logic          phase_r;

   // Divider counter and phase toggle on wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
         phase_r <= 1'b0;
      end else if (count_r == CNT_LAST) begin
         count_r <= {CW{1'b0}};
         phase_r <= ~phase_r;
      end else begin
         count_r <= count_r + CNT_ONE;
         phase_r <= phase_r;
      end
   end

   assign phase = phase_r;

endmodule

// File: rtl/menu_bar_n.sv
// -----------------------------------------------------------------------------
// menu_bar_n
// Tabbed menu bar drawn across the top of a 96x64 RGB565 OLED. Left/right
// buttons move a blinking cursor over N_TABS tiles, centre commits the cursor
// to active_tab, and the content area below the bar shows the pixel stream of
// the active source. An optional idle timeout pulls the cursor back to the
// committed tab.
//
// Ports
//   clk_menu      in   sole clock (pixel/menu clock)
//   reset         in   synchronous, active-high
//   coordinate_x  in   pixel column 0..95
//   coordinate_y  in   pixel row 0..63
//   src_data      in   16*N_TABS packed pixel words, slice k feeds tab k
//   pb_left       in   single-cycle button pulse
//   pb_right      in   single-cycle button pulse
//   pb_centre     in   single-cycle button pulse
//   menu_enable   in   buttons honoured when 1
//   sample_lock   in   all buttons ignored when 1
//   menu_color    out  registered pixel colour, 1 cycle after coordinates
//   cursor        out  highlighted tab index
//   active_tab    out  committed tab index
//   tab_changed   out  one-cycle pulse when active_tab changes value
// -----------------------------------------------------------------------------
module menu_bar_n
   import menu_bar_n_pkg::*;
#(
   parameter int          N_TABS      = 5,
   parameter int          WRAP        = 0,
   parameter int          BLINK_DIV   = 5_000_000,
   parameter int          IDLE_CYCLES = 0,
   parameter int          X0          = X0_DEF,
   parameter int          TAB_W       = TAB_W_DEF,
   parameter int          TAB_PITCH   = TAB_PITCH_DEF,
   parameter int          BAR_Y0      = BAR_Y0_DEF,
   parameter int          BAR_Y1      = BAR_Y1_DEF,
   parameter int          BAND_Y1     = BAND_Y1_DEF,
   parameter logic [15:0] COL_IDLE    = COL_IDLE_DEF,
   parameter logic [15:0] COL_CURSOR  = COL_CURSOR_DEF,
   parameter logic [15:0] COL_ACTIVE  = COL_ACTIVE_DEF,
   parameter logic [15:0] COL_BG      = COL_BG_DEF
) (
   input  logic                  clk_menu,
   input  logic                  reset,
   input  logic [7:0]            coordinate_x,
   input  logic [6:0]            coordinate_y,
   input  logic [16*N_TABS-1:0]  src_data,
   input  logic                  pb_left,
   input  logic                  pb_right,
   input  logic                  pb_centre,
   input  logic                  menu_enable,
   input  logic                  sample_lock,
   output logic [15:0]           menu_color,
   output logic [2:0]            cursor,
   output logic [2:0]            active_tab,
   output logic                  tab_changed
);

   localparam logic [2:0] LAST_TAB = 3'(N_TABS - 1);

   // Idle counter sized to hold IDLE_CYCLES; a single dormant bit when the
   // revert feature is disabled.
   localparam int             IW       = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [IW-1:0]  IDLE_MAX = IW'(IDLE_CYCLES);
   localparam logic [IW-1:0]  IDLE_ONE = IW'(1);

   logic           accept_s;
   logic           move_right_s;
   logic           move_left_s;
   logic           commit_s;
   logic           any_press_s;
   logic           revert_s;
   logic           blink_s;
   logic [2:0]     cursor_next_s;
   logic [IW-1:0]  idle_next_s;
   logic           hit_s;
   logic [2:0]     hit_idx_s;
   logic [15:0]    pix_color_s;

   logic [2:0]     cursor_r;
   logic [2:0]     active_tab_r;
   logic           tab_changed_r;
   logic [15:0]    menu_color_r;
   logic [IW-1:0]  idle_cnt_r;

   menu_blink_div #(
      .DIV (BLINK_DIV)
   ) u_blink (
      .clk   (clk_menu),
      .reset (reset),
      .phase (blink_s)
   );

   // Button qualification: left+right together cancel each other out
   always_comb begin
      accept_s     = menu_enable & ~sample_lock;
      move_right_s = accept_s & pb_right & ~pb_left;
      move_left_s  = accept_s & pb_left & ~pb_right;
      commit_s     = accept_s & pb_centre;
      any_press_s  = accept_s & (pb_left | pb_right | pb_centre);
   end

   // Idle timeout: revert fires on the single cycle the counter reaches its cap
   always_comb begin
      idle_next_s = idle_cnt_r;
      revert_s    = 1'b0;
      if (IDLE_CYCLES == 0) begin
         idle_next_s = {IW{1'b0}};
      end else if (any_press_s) begin
         idle_next_s = {IW{1'b0}};
      end else if (idle_cnt_r != IDLE_MAX) begin
         idle_next_s = idle_cnt_r + IDLE_ONE;
         revert_s    = (idle_cnt_r == (IDLE_MAX - IDLE_ONE));
      end else begin
         idle_next_s = idle_cnt_r;
      end
   end

   // Cursor movement; a revert can only occur in a cycle with no accepted press
   always_comb begin
      cursor_next_s = cursor_r;
      if (revert_s) begin
         cursor_next_s = active_tab_r;
      end else if (move_right_s) begin
         if (cursor_r == LAST_TAB) begin
            cursor_next_s = (WRAP != 0) ? 3'd0 : cursor_r;
         end else begin
            cursor_next_s = cursor_r + 3'd1;
         end
      end else if (move_left_s) begin
         if (cursor_r == 3'd0) begin
            cursor_next_s = (WRAP != 0) ? LAST_TAB : cursor_r;
         end else begin
            cursor_next_s = cursor_r - 3'd1;
         end
      end else begin
         cursor_next_s = cursor_r;
      end
   end

   // Tile hit test for the current pixel; tiles do not overlap, first hit wins
   always_comb begin
      hit_s     = 1'b0;
      hit_idx_s = 3'd0;
      for (int k = 0; k < N_TABS; k++) begin
         if (!hit_s &&
             (int'(coordinate_y) >= BAR_Y0) && (int'(coordinate_y) <= BAR_Y1) &&
             in_tile(int'(coordinate_x), k, X0, TAB_W, TAB_PITCH)) begin
            hit_s     = 1'b1;
            hit_idx_s = 3'(k);
         end else begin
            hit_s     = hit_s;
            hit_idx_s = hit_idx_s;
         end
      end
   end

   // Pixel colour priority: tile, then menu band background, then content
   always_comb begin
      pix_color_s = COL_BG;
      if (hit_s) begin
         if ((hit_idx_s == cursor_r) && blink_s) begin
            pix_color_s = COL_CURSOR;
         end else if (hit_idx_s == active_tab_r) begin
            pix_color_s = COL_ACTIVE;
         end else begin
            pix_color_s = COL_IDLE;
         end
      end else if (int'(coordinate_y) <= BAND_Y1) begin
         pix_color_s = COL_BG;
      end else begin
         pix_color_s = src_data[{active_tab_r, 4'b0000} +: 16];
      end
   end

   // Menu state and registered outputs; commit uses the pre-move cursor
   always_ff @(posedge clk_menu) begin
      if (reset) begin
         cursor_r      <= 3'd0;
         active_tab_r  <= 3'd0;
         tab_changed_r <= 1'b0;
         menu_color_r  <= 16'h0000;
         idle_cnt_r    <= {IW{1'b0}};
      end else begin
         cursor_r      <= cursor_next_s;
         active_tab_r  <= commit_s ? cursor_r : active_tab_r;
         tab_changed_r <= commit_s && (cursor_r != active_tab_r);
         menu_color_r  <= pix_color_s;
         idle_cnt_r    <= idle_next_s;
      end
   end

   assign cursor      = cursor_r;
   assign active_tab  = active_tab_r;
   assign tab_changed = tab_changed_r;
   assign menu_color  = menu_color_r;

endmodule

// File: tb/tb_menu_bar_n.sv
// -----------------------------------------------------------------------------
// tb_menu_bar_n
// Directed bench for menu_bar_n. Instance A: saturating cursor, no idle
// revert. Instance B: wrapping cursor with an 8-cycle idle revert. Both use a
// 4-cycle blink half-period so blink behaviour is observable.
// -----------------------------------------------------------------------------
module tb_menu_bar_n;

   localparam logic [15:0] C_IDLE   = 16'hAEDF;
   localparam logic [15:0] C_CURSOR = 16'hFAAE;
   localparam logic [15:0] C_BG     = 16'h10F2;

   logic        clk_menu;
   logic [7:0]  coordinate_x;
   logic [6:0]  coordinate_y;
   logic [79:0] src_data;
   logic        menu_enable;
   logic        sample_lock;

   logic        reset_a, pb_left_a, pb_right_a, pb_centre_a;
   logic [15:0] menu_color_a;
   logic [2:0]  cursor_a, active_tab_a;
   logic        tab_changed_a;

   logic        reset_b, pb_left_b, pb_right_b, pb_centre_b;
   logic [15:0] menu_color_b;
   logic [2:0]  cursor_b, active_tab_b;
   logic        tab_changed_b;

   int n_checks;
   int n_errors;

   menu_bar_n #(
      .N_TABS (5), .WRAP (0), .BLINK_DIV (4), .IDLE_CYCLES (0)
   ) dut_a (
      .clk_menu     (clk_menu),
      .reset        (reset_a),
      .coordinate_x (coordinate_x),
      .coordinate_y (coordinate_y),
      .src_data     (src_data),
      .pb_left      (pb_left_a),
      .pb_right     (pb_right_a),
      .pb_centre    (pb_centre_a),
      .menu_enable  (menu_enable),
      .sample_lock  (sample_lock),
      .menu_color   (menu_color_a),
      .cursor       (cursor_a),
      .active_tab   (active_tab_a),
      .tab_changed  (tab_changed_a)
   );

   menu_bar_n #(
      .N_TABS (5), .WRAP (1), .BLINK_DIV (4), .IDLE_CYCLES (8)
   ) dut_b (
      .clk_menu     (clk_menu),
      .reset        (reset_b),
      .coordinate_x (coordinate_x),
      .coordinate_y (coordinate_y),
      .src_data     (src_data),
      .pb_left      (pb_left_b),
      .pb_right     (pb_right_b),
      .pb_centre    (pb_centre_b),
      .menu_enable  (menu_enable),
      .sample_lock  (sample_lock),
      .menu_color   (menu_color_b),
      .cursor       (cursor_b),
      .active_tab   (active_tab_b),
      .tab_changed  (tab_changed_b)
   );

   // Clock generation
   initial clk_menu = 1'b0;
   always #5 clk_menu = ~clk_menu;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk_menu);
      #1;
   endtask

   // One-cycle button pulse on instance A (sel=0) or B (sel=1)
   task automatic press(input bit sel, input logic l, input logic r, input logic c);
      if (sel) begin
         pb_left_b = l; pb_right_b = r; pb_centre_b = c;
      end else begin
         pb_left_a = l; pb_right_a = r; pb_centre_a = c;
      end
      tick();
      pb_left_a = 1'b0; pb_right_a = 1'b0; pb_centre_a = 1'b0;
      pb_left_b = 1'b0; pb_right_b = 1'b0; pb_centre_b = 1'b0;
   endtask

   // Present a pixel to instance A and check the colour one cycle later
   task automatic pix(input string tag, input int x, input int y, input logic [15:0] exp);
      coordinate_x = 8'(x);
      coordinate_y = 7'(y);
      tick();
      check_eq(tag, int'(menu_color_a), int'(exp));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      coordinate_x = 8'd30;
      coordinate_y = 7'd5;
      src_data     = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
      menu_enable  = 1'b1;
      sample_lock  = 1'b0;
      pb_left_a = 1'b0; pb_centre_a = 1'b0;
      pb_left_b = 1'b0; pb_right_b = 1'b0; pb_centre_b = 1'b0;
      // Reset must win over a simultaneous button pulse
      pb_right_a = 1'b1;
      reset_a = 1'b1;
      reset_b = 1'b1;
      tick();
      tick();
      check_eq("rst_cursor_a", int'(cursor_a), 0);
      check_eq("rst_active_a", int'(active_tab_a), 0);
      check_eq("rst_changed_a", int'(tab_changed_a), 0);
      check_eq("rst_color_a", int'(menu_color_a), 0);
      check_eq("rst_cursor_b", int'(cursor_b), 0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      pb_right_a = 1'b0;

      // Saturating right moves
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("right_1", int'(cursor_a), 1);
      for (int i = 0; i < 5; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("right_sat", int'(cursor_a), 4);
      check_eq("right_sat_active", int'(active_tab_a), 0);

      // Commit and tab_changed pulse
      press(1'b0, 1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("left_to_2", int'(cursor_a), 2);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("commit_active", int'(active_tab_a), 2);
      check_eq("commit_pulse", int'(tab_changed_a), 1);
      tick();
      check_eq("commit_pulse_end", int'(tab_changed_a), 0);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("recommit_nopulse", int'(tab_changed_a), 0);
      check_eq("recommit_active", int'(active_tab_a), 2);

      // Lock, disable and left+right cancellation
      sample_lock = 1'b1;
      press(1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("lock_cursor", int'(cursor_a), 2);
      check_eq("lock_active", int'(active_tab_a), 2);
      sample_lock = 1'b0;
      press(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("lr_cancel", int'(cursor_a), 2);
      menu_enable = 1'b0;
      press(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("disabled", int'(cursor_a), 2);
      menu_enable = 1'b1;

      // Centre plus move: commit takes the pre-move cursor
      press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("cm_active", int'(active_tab_a), 3);
      check_eq("cm_cursor", int'(cursor_a), 4);
      check_eq("cm_pulse", int'(tab_changed_a), 1);
      for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("left_sat", int'(cursor_a), 0);

      // Wrapping instance
      press(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("wrap_left0", int'(cursor_b), 4);
      press(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("wrap_right4", int'(cursor_b), 0);
      press(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("wrap_left0_again", int'(cursor_b), 4);

      // Idle revert after 8 quiet cycles, no tab_changed
      press(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("idle_start", int'(cursor_b), 3);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_eq("idle_nopulse", int'(tab_changed_b), 0);
         if (i == 7) check_eq("idle_before", int'(cursor_b), 3);
         if (i == 8) check_eq("idle_revert", int'(cursor_b), 0);
      end
      check_eq("idle_active", int'(active_tab_b), 0);

      // Blink on tile 1 after a fresh reset of A (phase restarts at 0)
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int n = 2; n <= 13; n++) begin
         tick();
         check_eq("blink", int'(menu_color_a),
                  (((n - 1) / 4) % 2 == 1) ? int'(C_CURSOR) : int'(C_IDLE));
      end

      pix("gap_bg", 20, 5, C_BG);
      pix("content_0", 10, 20, 16'h1111);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("commit1_active", int'(active_tab_a), 1);
      check_eq("commit1_pulse", int'(tab_changed_a), 1);
      tick();
      check_eq("content_1", int'(menu_color_a), 16'h2222);
      src_data[31:16] = 16'hBEEF;
      tick();
      check_eq("content_latency", int'(menu_color_a), 16'hBEEF);

      // Tile and band boundaries (cursor=1, active=1)
      pix("tile0_right", 16, 5, C_IDLE);
      pix("tile0_after", 17, 5, C_BG);
      pix("tile0_left", 7, 3, C_IDLE);
      pix("tile0_before", 6, 3, C_BG);
      pix("tile4_corner", 88, 7, C_IDLE);
      pix("tile4_after", 89, 7, C_BG);
      pix("row8_bg", 80, 8, C_BG);
      pix("row10_bg", 80, 10, C_BG);
      pix("row11_src", 80, 11, 16'hBEEF);
      pix("col95_bg", 95, 5, C_BG);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
